// File: rtl/cpu_pkg.sv
// Shared decode constants, ALU codes and the decoded-control bundle for the
// MIPS-I integer-subset pipeline.
package cpu_pkg;

    localparam int ALUOP_W = 4;
    localparam int REG_AW  = 5;

    // Primary opcodes (Instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (Instruction[5:0])
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    // ALU operation codes
    localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_NOR  = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd8;
    localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd9;
    localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd10;
    localparam logic [ALUOP_W-1:0] ALU_LUI  = 4'd11;

    // Branch / jump encodings
    localparam logic [1:0] BR_NONE    = 2'b00;
    localparam logic [1:0] BR_BEQ     = 2'b01;
    localparam logic [1:0] BR_BNE     = 2'b10;
    localparam logic [1:0] JMP_NONE   = 2'b00;
    localparam logic [1:0] JMP_TARGET = 2'b01;
    localparam logic [1:0] JMP_REG    = 2'b10;

    localparam logic [REG_AW-1:0] REG_LINK = 5'd31;

    // Decoded control bundle; all-zero is a pipeline bubble.
    typedef struct packed {
        logic               reg_write;
        logic [REG_AW-1:0]  write_reg;
        logic [REG_AW-1:0]  read_reg1;
        logic [REG_AW-1:0]  read_reg2;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic [4:0]         shamt;
        logic [31:0]        imm_ext;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic [1:0]         branch;
        logic [1:0]         jump;
        logic               link;
        logic               illegal;
    } ctrl_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zero_ext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational instruction decoder producing the control bundle.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [31:0] instruction,
    output ctrl_t       ctrl
);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [4:0]        sh;
    logic [15:0]       imm;

    assign opcode = instruction[31:26];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign sh     = instruction[10:6];
    assign funct  = instruction[5:0];
    assign imm    = instruction[15:0];

    ctrl_t c;
    logic  bad;

    // Decode opcode/funct into control fields, then apply illegal and r0 overrides
    always_comb begin
        c           = '0;
        bad         = 1'b0;
        c.read_reg1 = rs;
        c.read_reg2 = rt;

        case (opcode)
            OP_RTYPE: begin
                c.write_reg = rd;
                c.reg_write = 1'b1;
                c.alu_src   = 1'b0;
                case (funct)
                    F_ADD, F_ADDU: c.alu_op = ALU_ADD;
                    F_SUB, F_SUBU: c.alu_op = ALU_SUB;
                    F_AND:         c.alu_op = ALU_AND;
                    F_OR:          c.alu_op = ALU_OR;
                    F_XOR:         c.alu_op = ALU_XOR;
                    F_NOR:         c.alu_op = ALU_NOR;
                    F_SLT:         c.alu_op = ALU_SLT;
                    F_SLTU:        c.alu_op = ALU_SLTU;
                    F_SLL: begin
                        c.alu_op = ALU_SLL;
                        c.shamt  = sh;
                    end
                    F_SRL: begin
                        c.alu_op = ALU_SRL;
                        c.shamt  = sh;
                    end
                    F_SRA: begin
                        c.alu_op = ALU_SRA;
                        c.shamt  = sh;
                    end
                    F_JR: begin
                        c.jump      = JMP_REG;
                        c.reg_write = 1'b0;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                c.write_reg = rt;
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.imm_ext   = sign_ext16(imm);
                case (opcode)
                    OP_SLTI:  c.alu_op = ALU_SLT;
                    OP_SLTIU: c.alu_op = ALU_SLTU;
                    OP_ANDI: begin
                        c.alu_op  = ALU_AND;
                        c.imm_ext = zero_ext16(imm);
                    end
                    OP_ORI: begin
                        c.alu_op  = ALU_OR;
                        c.imm_ext = zero_ext16(imm);
                    end
                    OP_XORI: begin
                        c.alu_op  = ALU_XOR;
                        c.imm_ext = zero_ext16(imm);
                    end
                    OP_LUI: begin
                        c.alu_op  = ALU_LUI;
                        c.imm_ext = {imm, 16'h0000};
                    end
                    OP_LW: begin
                        c.alu_op     = ALU_ADD;
                        c.mem_read   = 1'b1;
                        c.mem_to_reg = 1'b1;
                    end
                    default: c.alu_op = ALU_ADD;
                endcase
            end
            OP_SW: begin
                c.write_reg = rt;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_ADD;
                c.imm_ext   = sign_ext16(imm);
                c.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                // Compare rs against rt, so B comes from the register file
                c.write_reg = rt;
                c.alu_src   = 1'b0;
                c.alu_op    = ALU_SUB;
                c.imm_ext   = sign_ext16(imm);
                c.branch    = (opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
            end
            OP_J: begin
                c.jump = JMP_TARGET;
            end
            OP_JAL: begin
                c.jump      = JMP_TARGET;
                c.link      = 1'b1;
                c.reg_write = 1'b1;
                c.write_reg = REG_LINK;
            end
            default: bad = 1'b1;
        endcase

        // Unknown encodings collapse to a flagged bubble with no side effects
        if (bad) begin
            c           = '0;
            c.read_reg1 = rs;
            c.read_reg2 = rt;
            c.illegal   = 1'b1;
        end

        // r0 is hardwired, so never request a write to it
        if (c.write_reg == '0) begin
            c.reg_write = 1'b0;
        end

        ctrl = c;
    end

endmodule

// File: rtl/control_unit.sv
// ID stage: decodes the instruction and holds the result in the ID/EX register
// with stall (hold) and flush (bubble) control.
module control_unit
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instruction,
    input  logic               stall,
    input  logic               flush,
    output logic               reg_write,
    output logic [REG_AW-1:0]  write_reg,
    output logic [REG_AW-1:0]  read_reg1,
    output logic [REG_AW-1:0]  read_reg2,
    output logic               alu_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [4:0]         shamt,
    output logic [31:0]        imm_ext,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic [1:0]         branch,
    output logic [1:0]         jump,
    output logic               link,
    output logic               illegal
);

    ctrl_t dec_ctrl;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    ctrl_decode u_decode (
        .instruction (instruction),
        .ctrl        (dec_ctrl)
    );

    // Next ID/EX contents: flush beats stall beats a fresh decode
    always_comb begin
        ctrl_d = dec_ctrl;
        if (flush) begin
            ctrl_d = '0;
        end else if (stall) begin
            ctrl_d = ctrl_q;
        end
    end

    // ID/EX pipeline register, cleared to a bubble on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign reg_write  = ctrl_q.reg_write;
    assign write_reg  = ctrl_q.write_reg;
    assign read_reg1  = ctrl_q.read_reg1;
    assign read_reg2  = ctrl_q.read_reg2;
    assign alu_src    = ctrl_q.alu_src;
    assign alu_op     = ctrl_q.alu_op;
    assign shamt      = ctrl_q.shamt;
    assign imm_ext    = ctrl_q.imm_ext;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign branch     = ctrl_q.branch;
    assign jump       = ctrl_q.jump;
    assign link       = ctrl_q.link;
    assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector testbench for control_unit.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        stall;
    logic        flush;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic [4:0]  shamt;
    logic [31:0] imm_ext;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [1:0]  branch;
    logic [1:0]  jump;
    logic        link;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    control_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .stall       (stall),
        .flush       (flush),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .read_reg1   (read_reg1),
        .read_reg2   (read_reg2),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .shamt       (shamt),
        .imm_ext     (imm_ext),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .branch      (branch),
        .jump        (jump),
        .link        (link),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic any_out;
    assign any_out = |{reg_write, write_reg, read_reg1, read_reg2, alu_src, alu_op,
                       shamt, imm_ext, mem_read, mem_write, mem_to_reg, branch,
                       jump, link, illegal};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present an instruction at the falling edge, sample #1 after the next rising edge
    task automatic step(input logic [31:0] instr);
        @(negedge clk);
        instruction = instr;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input logic [31:0] instr,
                           input logic rw, input logic [4:0] wr,
                           input logic [4:0] rr1, input logic [4:0] rr2,
                           input logic src, input logic [3:0] op,
                           input logic [4:0] sh, input logic [31:0] imm,
                           input logic mr, input logic mw, input logic m2r,
                           input logic [1:0] br, input logic [1:0] jp,
                           input logic ln, input logic il);
        step(instr);
        $display("vec %-6s instr=0x%08h rw=%0d wr=%0d rr1=%0d rr2=%0d src=%0d op=%0d imm=0x%08h ill=%0d",
                 tag, instr, reg_write, write_reg, read_reg1, read_reg2, alu_src, alu_op, imm_ext, illegal);
        check_eq({tag, ".reg_write"},  32'(reg_write),  32'(rw));
        check_eq({tag, ".write_reg"},  32'(write_reg),  32'(wr));
        check_eq({tag, ".read_reg1"},  32'(read_reg1),  32'(rr1));
        check_eq({tag, ".read_reg2"},  32'(read_reg2),  32'(rr2));
        check_eq({tag, ".alu_src"},    32'(alu_src),    32'(src));
        check_eq({tag, ".alu_op"},     32'(alu_op),     32'(op));
        check_eq({tag, ".shamt"},      32'(shamt),      32'(sh));
        check_eq({tag, ".imm_ext"},    imm_ext,         imm);
        check_eq({tag, ".mem_read"},   32'(mem_read),   32'(mr));
        check_eq({tag, ".mem_write"},  32'(mem_write),  32'(mw));
        check_eq({tag, ".mem_to_reg"}, 32'(mem_to_reg), 32'(m2r));
        check_eq({tag, ".branch"},     32'(branch),     32'(br));
        check_eq({tag, ".jump"},       32'(jump),       32'(jp));
        check_eq({tag, ".link"},       32'(link),       32'(ln));
        check_eq({tag, ".illegal"},    32'(illegal),    32'(il));
    endtask

    initial begin
        rst_n       = 1'b0;
        instruction = 32'h0022_1820;
        stall       = 1'b0;
        flush       = 1'b0;

        // Reset state, before and across a clock edge
        #2;
        check_eq("reset_pre_edge", 32'(any_out), 32'd0);
        @(posedge clk);
        #1;
        check_eq("reset_held", 32'(any_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //       tag       instr         rw wr  rr1 rr2 src op  sh   imm            mr mw m2r br     jp     ln il
        run_vec("add",   32'h0022_1820, 1, 3,  1,  2,  0,  0,  0, 32'h0000_0000, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        run_vec("addi",  32'h2001_0005, 1, 1,  0,  1,  1,  0,  0, 32'h0000_0005, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        run_vec("sub",   32'h0022_1822, 1, 3,  1,  2,  0,  1,  0, 32'h0000_0000, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        run_vec("lw",    32'h8CA4_FFFC, 1, 4,  5,  4,  1,  0,  0, 32'hFFFF_FFFC, 1, 0, 1, 2'b00, 2'b00, 0, 0);
        run_vec("ori",   32'h3405_FFFF, 1, 5,  0,  5,  1,  3,  0, 32'h0000_FFFF, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        run_vec("nop",   32'h0000_0000, 0, 0,  0,  0,  0,  8,  0, 32'h0000_0000, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        run_vec("illop", 32'hFC00_0000, 0, 0,  0,  0,  0,  0,  0, 32'h0000_0000, 0, 0, 0, 2'b00, 2'b00, 0, 1);
        run_vec("beq",   32'h1022_0003, 0, 2,  1,  2,  0,  1,  0, 32'h0000_0003, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        run_vec("bne",   32'h1422_FFFF, 0, 2,  1,  2,  0,  1,  0, 32'hFFFF_FFFF, 0, 0, 0, 2'b10, 2'b00, 0, 0);
        run_vec("jr",    32'h03E0_0008, 0, 0, 31,  0,  0,  0,  0, 32'h0000_0000, 0, 0, 0, 2'b00, 2'b10, 0, 0);
        run_vec("jal",   32'h0C00_0010, 1, 31, 0,  0,  0,  0,  0, 32'h0000_0000, 0, 0, 0, 2'b00, 2'b01, 1, 0);
        run_vec("j",     32'h0800_0010, 0, 0,  0,  0,  0,  0,  0, 32'h0000_0000, 0, 0, 0, 2'b00, 2'b01, 0, 0);
        run_vec("sra",   32'h0003_1083, 1, 2,  0,  3,  0, 10,  2, 32'h0000_0000, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        run_vec("lui",   32'h3C01_1234, 1, 1,  0,  1,  1, 11,  0, 32'h1234_0000, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        run_vec("sw",    32'hAC45_0008, 0, 5,  2,  5,  1,  0,  0, 32'h0000_0008, 0, 1, 0, 2'b00, 2'b00, 0, 0);
        run_vec("illfn", 32'h0022_183F, 0, 0,  1,  2,  0,  0,  0, 32'h0000_0000, 0, 0, 0, 2'b00, 2'b00, 0, 1);
        run_vec("addir0",32'h2000_0005, 0, 0,  0,  0,  1,  0,  0, 32'h0000_0005, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        run_vec("slti",  32'h2822_FFF0, 1, 2,  1,  2,  1,  6,  0, 32'hFFFF_FFF0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        run_vec("andi",  32'h3022_FFF0, 1, 2,  1,  2,  1,  2,  0, 32'h0000_FFF0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

        // Stall: load add, then hold for 3 cycles while the instruction changes
        run_vec("add2",  32'h0022_1820, 1, 3,  1,  2,  0,  0,  0, 32'h0000_0000, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        stall = 1'b1;
        step(32'h8CA4_FFFC);
        $display("stall cycle 1: wr=%0d op=%0d mr=%0d", write_reg, alu_op, mem_read);
        check_eq("stall1.write_reg", 32'(write_reg), 32'd3);
        check_eq("stall1.mem_read",  32'(mem_read),  32'd0);
        step(32'hAC45_0008);
        $display("stall cycle 2: wr=%0d op=%0d mw=%0d", write_reg, alu_op, mem_write);
        check_eq("stall2.reg_write", 32'(reg_write), 32'd1);
        check_eq("stall2.mem_write", 32'(mem_write), 32'd0);
        step(32'hFC00_0000);
        $display("stall cycle 3: wr=%0d rr1=%0d ill=%0d", write_reg, read_reg1, illegal);
        check_eq("stall3.read_reg1", 32'(read_reg1), 32'd1);
        check_eq("stall3.illegal",   32'(illegal),   32'd0);
        stall = 1'b0;
        run_vec("sub2",  32'h0022_1822, 1, 3,  1,  2,  0,  1,  0, 32'h0000_0000, 0, 0, 0, 2'b00, 2'b00, 0, 0);

        // Flush wins over stall and loads a bubble
        flush = 1'b1;
        stall = 1'b1;
        step(32'h8CA4_FFFC);
        $display("flush: any_out=%0d", any_out);
        check_eq("flush_bubble", 32'(any_out), 32'd0);
        flush = 1'b0;
        stall = 1'b0;
        run_vec("lw2",   32'h8CA4_FFFC, 1, 4,  5,  4,  1,  0,  0, 32'hFFFF_FFFC, 1, 0, 1, 2'b00, 2'b00, 0, 0);

        // Asynchronous reset mid-stream: outputs clear before any clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: any_out=%0d", any_out);
        check_eq("async_reset", 32'(any_out), 32'd0);
        @(posedge clk);
        #1;
        check_eq("reset_hold_edge", 32'(any_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("add3",  32'h0022_1820, 1, 3,  1,  2,  0,  0,  0, 32'h0000_0000, 0, 0, 0, 2'b00, 2'b00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
